// File: rtl/piano_pkg.sv
// Shared constants and note helpers for the piano voice allocator.
package piano_pkg;

  localparam int unsigned NOTE_W_DEFAULT = 7;
  localparam int unsigned PC_N           = 12;

  localparam logic [3:0] NOTE_C  = 4'd1;
  localparam logic [3:0] NOTE_CS = 4'd2;
  localparam logic [3:0] NOTE_D  = 4'd3;
  localparam logic [3:0] NOTE_DS = 4'd4;
  localparam logic [3:0] NOTE_E  = 4'd5;
  localparam logic [3:0] NOTE_F  = 4'd6;
  localparam logic [3:0] NOTE_FS = 4'd7;
  localparam logic [3:0] NOTE_G  = 4'd8;
  localparam logic [3:0] NOTE_GS = 4'd9;
  localparam logic [3:0] NOTE_A  = 4'd10;
  localparam logic [3:0] NOTE_AS = 4'd11;
  localparam logic [3:0] NOTE_B  = 4'd12;

  // Full note number: octave*12 + (pitch class - 1).
  function automatic logic [NOTE_W_DEFAULT-1:0] full_note(input logic [2:0] octave,
                                                          input logic [3:0] note_id);
    logic [NOTE_W_DEFAULT-1:0] w_oct;
    logic [NOTE_W_DEFAULT-1:0] w_id;
    w_oct = NOTE_W_DEFAULT'(octave);
    w_id  = NOTE_W_DEFAULT'(note_id);
    return (w_oct * NOTE_W_DEFAULT'(PC_N)) + w_id - NOTE_W_DEFAULT'(1);
  endfunction

  // One-hot pitch class of a full note, bit 0 = C.
  function automatic logic [PC_N-1:0] pc_onehot(input logic [NOTE_W_DEFAULT-1:0] note);
    logic [NOTE_W_DEFAULT-1:0] w_pc;
    w_pc = note % NOTE_W_DEFAULT'(PC_N);
    return PC_N'(1) << w_pc;
  endfunction

  // Pitch classes 1..12 are playable; anything else is dropped.
  function automatic logic note_id_valid(input logic [3:0] note_id);
    return (note_id >= NOTE_C) && (note_id <= NOTE_B);
  endfunction

endpackage

// File: rtl/piano_voice_select.sv
// Combinational voice search: matching voice, lowest free voice, oldest voice.
module piano_voice_select
  import piano_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned AGE_W      = 8,
  parameter int unsigned NOTE_W     = NOTE_W_DEFAULT,
  parameter int unsigned IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic [NUM_VOICES-1:0]        gates,
  input  logic [NUM_VOICES*NOTE_W-1:0] notes,
  input  logic [NUM_VOICES*AGE_W-1:0]  ages,
  input  logic [NOTE_W-1:0]            ev_note,
  output logic                         match_hit,
  output logic [IDX_W-1:0]             match_idx,
  output logic                         free_hit,
  output logic [IDX_W-1:0]             free_idx,
  output logic [IDX_W-1:0]             oldest_idx
);

  logic [AGE_W-1:0] w_best_age;

  // Linear scan; strict compare keeps the lowest index on age ties.
  always_comb begin
    match_hit  = 1'b0;
    match_idx  = '0;
    free_hit   = 1'b0;
    free_idx   = '0;
    oldest_idx = '0;
    w_best_age = ages[AGE_W-1:0];
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!match_hit && gates[i] && (notes[i*NOTE_W +: NOTE_W] == ev_note)) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!free_hit && !gates[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (ages[i*AGE_W +: AGE_W] > w_best_age) begin
        w_best_age = ages[i*AGE_W +: AGE_W];
        oldest_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/piano_voice_allocator.sv
// Polyphonic voice allocator: press/retrigger/steal, release, sustain hold.
module piano_voice_allocator
  import piano_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned AGE_W      = 8,
  parameter int unsigned NOTE_W     = NOTE_W_DEFAULT
) (
  input  logic                         CLK100MHZ,
  input  logic                         CPU_RESETN,
  input  logic                         play_en,
  input  logic                         key_valid,
  input  logic                         key_release,
  input  logic [3:0]                   note_id,
  input  logic [2:0]                   octave,
  input  logic                         sustain,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [PC_N-1:0]              key_status,
  output logic                         steal
);

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [NUM_VOICES-1:0]        r_gate;
  logic [NUM_VOICES-1:0]        r_held;
  logic [NUM_VOICES*NOTE_W-1:0] r_note;
  logic [NUM_VOICES*AGE_W-1:0]  r_age;
  logic                         r_sus;
  logic [PC_N-1:0]              r_key_status;
  logic                         r_steal;

  logic [NUM_VOICES-1:0]        w_gate_nx;
  logic [NUM_VOICES-1:0]        w_held_nx;
  logic [NUM_VOICES*NOTE_W-1:0] w_note_nx;
  logic [NUM_VOICES*AGE_W-1:0]  w_age_nx;
  logic [PC_N-1:0]              w_ks_nx;
  logic                         w_steal_nx;

  logic [NOTE_W-1:0] w_ev_note;
  logic              w_accept;
  logic              w_fall;
  logic              w_match_hit;
  logic              w_free_hit;
  logic [IDX_W-1:0]  w_match_idx;
  logic [IDX_W-1:0]  w_free_idx;
  logic [IDX_W-1:0]  w_oldest_idx;
  logic [IDX_W-1:0]  w_tgt;

  assign w_ev_note = NOTE_W'(full_note(octave, note_id));
  assign w_accept  = key_valid && play_en && note_id_valid(note_id);
  assign w_fall    = r_sus && !sustain;

  // Search runs on pre-cycle state only.
  piano_voice_select #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W),
    .NOTE_W     (NOTE_W),
    .IDX_W      (IDX_W)
  ) u_select (
    .gates      (r_gate),
    .notes      (r_note),
    .ages       (r_age),
    .ev_note    (w_ev_note),
    .match_hit  (w_match_hit),
    .match_idx  (w_match_idx),
    .free_hit   (w_free_hit),
    .free_idx   (w_free_idx),
    .oldest_idx (w_oldest_idx)
  );

  // Next-state: sustain release first, then the event overrides its target voice.
  always_comb begin
    w_gate_nx  = r_gate;
    w_held_nx  = r_held;
    w_note_nx  = r_note;
    w_age_nx   = r_age;
    w_steal_nx = 1'b0;
    w_ks_nx    = '0;
    w_tgt      = w_match_hit ? w_match_idx : (w_free_hit ? w_free_idx : w_oldest_idx);

    if (!play_en) begin
      w_gate_nx = '0;
      w_held_nx = '0;
      w_age_nx  = '0;
    end else begin
      if (w_fall) begin
        w_gate_nx = r_gate & ~r_held;
        w_held_nx = '0;
      end
      if (w_accept && !key_release) begin
        w_steal_nx = !w_match_hit && !w_free_hit;
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (IDX_W'(i) == w_tgt) begin
            w_gate_nx[i]                 = 1'b1;
            w_held_nx[i]                 = 1'b0;
            w_age_nx[i*AGE_W +: AGE_W]   = '0;
            w_note_nx[i*NOTE_W +: NOTE_W] = w_ev_note;
          end else if (r_gate[i] && (r_age[i*AGE_W +: AGE_W] != AGE_MAX)) begin
            w_age_nx[i*AGE_W +: AGE_W] = r_age[i*AGE_W +: AGE_W] + AGE_W'(1);
          end
        end
      end else if (w_accept && key_release && w_match_hit) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (IDX_W'(i) == w_match_idx) begin
            if (!sustain) begin
              w_gate_nx[i] = 1'b0;
              w_held_nx[i] = 1'b0;
            end else begin
              w_held_nx[i] = 1'b1;
            end
          end
        end
      end
    end

    for (int i = 0; i < NUM_VOICES; i++) begin
      if (w_gate_nx[i]) begin
        w_ks_nx = w_ks_nx | pc_onehot(NOTE_W_DEFAULT'(w_note_nx[i*NOTE_W +: NOTE_W]));
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_gate       <= '0;
      r_held       <= '0;
      r_note       <= '0;
      r_age        <= '0;
      r_sus        <= 1'b0;
      r_key_status <= '0;
      r_steal      <= 1'b0;
    end else begin
      r_gate       <= w_gate_nx;
      r_held       <= w_held_nx;
      r_note       <= w_note_nx;
      r_age        <= w_age_nx;
      r_sus        <= sustain;
      r_key_status <= w_ks_nx;
      r_steal      <= w_steal_nx;
    end
  end

  assign voice_gate = r_gate;
  assign voice_note = r_note;
  assign key_status = r_key_status;
  assign steal      = r_steal;

endmodule

// File: tb/tb_piano_voice_allocator.sv
// Directed plus randomized checks of the voice allocator against a voice-table model.
module tb_piano_voice_allocator;

  localparam int NV  = 4;
  localparam int NW  = 7;
  localparam int AMX = 255;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           play_en = 1'b0;
  logic           key_valid = 1'b0;
  logic           key_release = 1'b0;
  logic [3:0]     note_id = 4'd0;
  logic [2:0]     octave = 3'd0;
  logic           sustain = 1'b0;
  logic [NV-1:0]  voice_gate;
  logic [NV*NW-1:0] voice_note;
  logic [11:0]    key_status;
  logic           steal;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference voice table
  int m_gate [NV];
  int m_held [NV];
  int m_note [NV];
  int m_age  [NV];
  int m_sus;
  int m_steal;

  piano_voice_allocator #(.NUM_VOICES(NV), .AGE_W(8), .NOTE_W(NW)) dut (
    .CLK100MHZ   (clk),
    .CPU_RESETN  (rst_n),
    .play_en     (play_en),
    .key_valid   (key_valid),
    .key_release (key_release),
    .note_id     (note_id),
    .octave      (octave),
    .sustain     (sustain),
    .voice_gate  (voice_gate),
    .voice_note  (voice_note),
    .key_status  (key_status),
    .steal       (steal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_gate[i] = 0; m_held[i] = 0; m_note[i] = 0; m_age[i] = 0;
    end
    m_sus = 0;
    m_steal = 0;
  endtask

  // One clock of the allocation rules, decisions taken from the pre-cycle table.
  task automatic model_step(input int v, input int rel, input int nid, input int oct,
                            input int sus, input int pen);
    int pg [NV];
    int pn [NV];
    int pa [NV];
    int fn, mi, fi, oi, tgt;
    for (int i = 0; i < NV; i++) begin
      pg[i] = m_gate[i]; pn[i] = m_note[i]; pa[i] = m_age[i];
    end
    m_steal = 0;
    if (pen == 0) begin
      for (int i = 0; i < NV; i++) begin
        m_gate[i] = 0; m_held[i] = 0; m_age[i] = 0;
      end
    end else begin
      if (m_sus == 1 && sus == 0) begin
        for (int i = 0; i < NV; i++)
          if (m_held[i] == 1) begin m_gate[i] = 0; m_held[i] = 0; end
      end
      if (v == 1 && nid >= 1 && nid <= 12) begin
        fn = oct * 12 + nid - 1;
        mi = -1; fi = -1; oi = 0;
        for (int i = NV - 1; i >= 0; i--) begin
          if (pg[i] == 1 && pn[i] == fn) mi = i;
          if (pg[i] == 0) fi = i;
        end
        for (int i = 1; i < NV; i++)
          if (pa[i] > pa[oi]) oi = i;
        if (rel == 0) begin
          tgt = (mi >= 0) ? mi : ((fi >= 0) ? fi : oi);
          if (mi < 0 && fi < 0) m_steal = 1;
          for (int i = 0; i < NV; i++)
            if (i != tgt && pg[i] == 1) m_age[i] = (pa[i] + 1 > AMX) ? AMX : pa[i] + 1;
          m_gate[tgt] = 1; m_held[tgt] = 0; m_age[tgt] = 0; m_note[tgt] = fn;
        end else if (mi >= 0) begin
          if (sus == 0) begin m_gate[mi] = 0; m_held[mi] = 0; end
          else m_held[mi] = 1;
        end
      end
    end
    m_sus = sus;
  endtask

  task automatic check_all(input string tag);
    logic [NV-1:0]    eg;
    logic [NV*NW-1:0] en;
    logic [11:0]      ek;
    ek = '0;
    for (int i = 0; i < NV; i++) begin
      eg[i] = (m_gate[i] == 1);
      en[i*NW +: NW] = NW'(m_note[i]);
      if (m_gate[i] == 1) ek = ek | (12'(1) << (m_note[i] % 12));
    end
    check({tag, "_gate"},  64'(voice_gate), 64'(eg));
    check({tag, "_note"},  64'(voice_note), 64'(en));
    check({tag, "_ks"},    64'(key_status), 64'(ek));
    check({tag, "_steal"}, 64'(steal),      64'(m_steal));
  endtask

  task automatic step(input string tag, input int v, input int rel, input int nid,
                      input int oct, input int sus, input int pen);
    key_valid = 1'(v); key_release = 1'(rel); note_id = 4'(nid);
    octave = 3'(oct); sustain = 1'(sus); play_en = 1'(pen);
    @(posedge clk);
    model_step(v, rel, nid, oct, sus, pen);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse taken between clock edges.
  task automatic mid_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2;
    rst_n = 1'b1;
  endtask

  int sus_r;

  initial begin
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Allocate C4 E4 G4
    step("alloc_c4", 1, 0, 1, 4, 0, 1);
    step("alloc_e4", 1, 0, 5, 4, 0, 1);
    step("alloc_g4", 1, 0, 8, 4, 0, 1);
    check("alloc_ks_const",   64'(key_status), 64'(12'h091));
    check("alloc_gate_const", 64'(voice_gate), 64'(4'b0111));
    check("alloc_note_const", 64'(voice_note), 64'({7'd0, 7'd55, 7'd52, 7'd48}));

    // Invalid note ids are dropped, then play_en off clears all gates
    step("inv_0",  1, 0, 0, 4, 0, 1);
    step("inv_13", 1, 0, 13, 4, 0, 1);
    check("inv_gate_const", 64'(voice_gate), 64'(4'b0111));
    step("play_off", 0, 0, 0, 0, 0, 0);
    check("play_off_const", 64'(voice_gate), 64'(4'b0000));

    // Steal: five distinct presses
    step("st_c4", 1, 0, 1, 4, 0, 1);
    step("st_d4", 1, 0, 3, 4, 0, 1);
    step("st_e4", 1, 0, 5, 4, 0, 1);
    step("st_f4", 1, 0, 6, 4, 0, 1);
    step("st_g4", 1, 0, 8, 4, 0, 1);
    check("steal_pulse_const", 64'(steal), 64'(1));
    check("steal_note_const",  64'(voice_note), 64'({7'd53, 7'd52, 7'd50, 7'd55}));
    step("st_idle", 0, 0, 0, 0, 0, 1);
    check("steal_drop_const", 64'(steal), 64'(0));
    step("st_off", 0, 0, 0, 0, 0, 0);

    // Retrigger: C4 D4 C4, then fill and steal to expose the ages
    step("rt_c4a", 1, 0, 1, 4, 0, 1);
    step("rt_d4",  1, 0, 3, 4, 0, 1);
    step("rt_c4b", 1, 0, 1, 4, 0, 1);
    check("rt_gate_const", 64'(voice_gate), 64'(4'b0011));
    step("rt_e4", 1, 0, 5, 4, 0, 1);
    step("rt_f4", 1, 0, 6, 4, 0, 1);
    step("rt_g4", 1, 0, 8, 4, 0, 1);
    check("rt_steal_note_const", 64'(voice_note[NW +: NW]), 64'(55));
    step("rt_off", 0, 0, 0, 0, 0, 0);

    // Sustain hold of A3, then pedal drop with a simultaneous B3 press
    step("su_on",  0, 0, 0, 0, 1, 1);
    step("su_a3",  1, 0, 10, 3, 1, 1);
    step("su_rel", 1, 1, 10, 3, 1, 1);
    check("su_hold_const", 64'(voice_gate), 64'(4'b0001));
    step("su_drop", 1, 0, 12, 3, 0, 1);
    check("su_drop_const", 64'(voice_gate), 64'(4'b0010));
    step("su_off", 0, 0, 0, 0, 0, 0);

    // Reset between strobes
    step("mr_c4", 1, 0, 1, 4, 0, 1);
    step("mr_d4", 1, 0, 3, 4, 0, 1);
    mid_reset("mr_async");
    step("mr_e4", 1, 0, 5, 4, 0, 1);
    check("mr_first_const", 64'(voice_gate), 64'(4'b0001));

    // Randomized traffic
    sus_r = 0;
    for (int k = 0; k < 400; k++) begin
      int v, rel, nid, oct, pen;
      v   = ($urandom % 10 < 7) ? 1 : 0;
      rel = ($urandom % 5 < 2) ? 1 : 0;
      nid = ($urandom % 10 == 0) ? (($urandom % 2 == 0) ? 0 : int'($urandom_range(13, 15)))
                                 : int'($urandom_range(1, 12));
      oct = int'($urandom_range(3, 4));
      if ($urandom % 10 == 0) sus_r = 1 - sus_r;
      pen = ($urandom % 40 == 0) ? 0 : 1;
      step("rnd", v, rel, nid, oct, sus_r, pen);
      if (k % 131 == 77) mid_reset("rnd_reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piano_voice_allocator.md
# piano_voice_allocator

Polyphonic voice allocator between the PS/2 keyboard decode path and the tone generators. Consumes one decoded piano-key event per cycle and assigns it to one of `NUM_VOICES` voices. Supports retrigger, sustain-pedal hold, and oldest-voice stealing when all voices are busy. Drives per-voice gate and note registers for a bank of voice oscillators. Replaces the single 12-bit key-status vector with true multi-octave polyphony.

## Interface
- `NUM_VOICES`, default 4: number of voices; range 1..16.
- `AGE_W`, default 8: width of the per-voice saturating age counter.
- `NOTE_W`, default 7: full-note width; note = octave*12 + (note_id-1), range 0..95.

- `CLK100MHZ`, in, 1: system clock.
- `CPU_RESETN`, in, 1: reset, asynchronous, active-low.
- `play_en`, in, 1: 0 forces all voices off and ignores events.
- `key_valid`, in, 1: single-cycle event strobe.
- `key_release`, in, 1: qualifies `key_valid`; 1 = release, 0 = press.
- `note_id`, in, 4: pitch class 1..12 (C..B); 0 and 13..15 are invalid and the event is dropped.
- `octave`, in, 3: octave 0..7, sampled with the event.
- `sustain`, in, 1: sustain pedal, level.
- `voice_gate`, out, NUM_VOICES: per-voice gate.
- `voice_note`, out, NUM_VOICES*NOTE_W: packed per-voice full note; voice i occupies bits [i*NOTE_W +: NOTE_W].
- `key_status`, out, 12: OR over gated voices of the one-hot pitch class; bit 0 = C.
- `steal`, out, 1: one-cycle pulse when a press steals a busy voice.

## Operation
- Per-voice state: `gate`, `held`, `note`, `age`. An event is accepted when `key_valid && play_en` and `note_id` is valid.
- **Free voice**: `gate==0`. **Match**: `gate==1 && note==full_note`.
- **Press, matching voice exists**: retrigger.
  - Set `age` to 0 and clear `held`; `gate` stays 1.
  - No other voice changes except the age increment below.
- **Press, no match, free voice exists**: allocate the lowest-index free voice.
  - Set `gate` to 1, `note` to `full_note`, `age` to 0, `held` to 0.
- **Press, no match, no free voice**: steal.
  - Target is the voice with the largest `age`; ties go to the lowest index.
  - Load it as an allocation and pulse `steal`.
- **Press, any case**: every other gated voice increments `age`, saturating at 2^AGE_W-1.
- **Release, match**:
  - If `sustain==0`, clear `gate`.
  - Otherwise set `held` and keep `gate`.
  - At most one voice can match. Duplicate notes cannot exist because presses retrigger.
- **Release, no match**: ignored.
- **Sustain 1->0 edge**: every voice with `held==1` clears `gate` and `held` in the same cycle. The edge is detected against a registered copy of `sustain`.
- **Event and sustain falling edge in the same cycle**:
  - Both take effect.
  - Free-voice selection uses pre-cycle state, so voices freed by the edge are not free for this press.
  - A voice that is retriggered this cycle is not freed by the edge.
- **`play_en==0`**: next edge clears all `gate`, `held` and `age`. `note` holds its value. Events are ignored.
- `key_status` and `steal` are registered. `key_status` reflects the gates after the update.
- **Reset values**: all `gate`, `held`, `age`, `note` = 0; `voice_gate` = 0; `voice_note` = 0; `key_status` = 0; `steal` = 0; sustain register = 0.

## Timing
- 1-cycle latency: an event at edge N is visible on `voice_gate`, `voice_note`, `key_status` and `steal` after edge N.
- Back-to-back events on consecutive cycles are fully supported, with no stall and no backpressure.
- Selection logic (match, free search, oldest search) is combinational from registered state. The critical path is an O(NUM_VOICES) compare tree, which closes at 100 MHz for NUM_VOICES ≤ 16.
- Reset assertion clears state immediately, mid-event included. The first event is accepted on the first edge after deassertion.

## Structure
- `piano_pkg` holds:
  - the `NOTE_W` default;
  - localparams `NOTE_C`..`NOTE_B` = 1..12;
  - function `full_note(octave, note_id)`;
  - function `pc_onehot(note)` returning 12 bits.
- Sub-module `piano_voice_select` is purely combinational.
  - Inputs: gates, notes, ages, and the event's full note.
  - Outputs: `match_hit`/`match_idx`, `free_hit`/`free_idx`, `oldest_idx`.
- The top level holds all registers and the update logic.

## Test plan
- **Allocate**: reset, then press C4 (note_id 1, octave 4, note 48), E4, G4. Required: voices 0..2 gated with notes 48/52/55, `key_status`=0x091, `steal`=0.
- **Steal**: NUM_VOICES=4; press 5 distinct notes on consecutive cycles. Required: the 5th press lands in voice 0 (the oldest), `steal` pulses for one cycle, and the other voices are unchanged.
- **Retrigger**: press C4, press D4, press C4 again. Required: C4 stays in voice 0 with age 0, D4's age is 1, and no third voice is gated.
- **Sustain**: with `sustain`=1, press and release A3 (note 45). Required: gate stays 1 and `held`=1. Dropping `sustain` clears the gate one cycle later; a press in the drop cycle does not take that voice.
- **play_en / invalid**: press with note_id 0 or 13. Required: no change. Drop `play_en` with 3 voices active. Required: all gates 0 next cycle.
- **Reset mid-stream**: assert `CPU_RESETN`=0 between two event strobes. Required: all outputs go to 0 asynchronously, and the first event after release allocates voice 0.
